// File: rtl/sphere_packet_receiver_pkg.sv
// Shared types and constants for the sphere packet receiver.
// Build option: PKT_CHECKSUM_EN appends an XOR checksum byte to every packet.
package Types;

   localparam int unsigned PKT_PAYLOAD_BYTES = 8;
   localparam int unsigned SPHERE_W          = 64;

`ifdef PKT_CHECKSUM_EN
   localparam int unsigned PKT_BYTES = PKT_PAYLOAD_BYTES + 1;
`else
   localparam int unsigned PKT_BYTES = PKT_PAYLOAD_BYTES;
`endif

   // Wide enough to count every byte of a packet, checksum included
   localparam int unsigned BYTE_CNT_W = 4;

   // Status byte layout: {ovf, err, 3'b0, level[2:0]}
   localparam int unsigned ST_OVF_BIT = 7;
   localparam int unsigned ST_ERR_BIT = 6;
   localparam int unsigned ST_LEVEL_W = 3;
   localparam int unsigned ST_LEVEL_MAX = 7;

   typedef logic [SPHERE_W-1:0] Sphere;

   typedef enum logic [1:0] {
      ASM_IDLE     = 2'd0,
      ASM_ASSEMBLE = 2'd1,
      ASM_COMMIT   = 2'd2
   } asm_state_t;

endpackage

// File: rtl/sphere_packet_receiver_word_fifo.sv
// Synchronous DEPTH x W FIFO with registered full/empty/level.
// Ports: clk, rst (sync, active-high), push/din, pop/head_c (combinational
// view of the head entry), full, empty, level (occupancy).
// A push while full is accepted only if a pop happens in the same cycle.
module word_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               din,
   input  logic                       pop,
   output logic [W-1:0]               head_c,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push_c;
   logic             do_pop_c;
   logic [LVL_W-1:0] level_nxt_c;

   // Qualify requests and compute next occupancy
   always_comb begin
      do_push_c   = push && (!full || pop);
      do_pop_c    = pop && !empty;
      level_nxt_c = level;
      if (do_push_c && !do_pop_c) begin
         level_nxt_c = level + LVL_W'(1);
      end else if (!do_push_c && do_pop_c) begin
         level_nxt_c = level - LVL_W'(1);
      end
   end

   // Pointers and flags; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         level <= level_nxt_c;
         full  <= (level_nxt_c == LVL_W'(DEPTH));
         empty <= (level_nxt_c == '0);
      end
   end

   // Storage needs no reset; the pointers define validity
   always_ff @(posedge clk) begin
      if (do_push_c) mem[wr_ptr] <= din;
   end

   assign head_c = mem[rd_ptr];

endmodule

// File: rtl/sphere_packet_receiver.sv
// Assembles SPI bytes into 64-bit sphere words, buffers them, and delivers
// one word per rising edge of the controller's recv_interrupt.
// Ports: CLK100MHZ, ck_rst (sync, active-high); spi_frame_active,
// spi_byte_dv, spi_byte from the SPI slave; recv_interrupt from the
// controller; recv_dv/recv_64bit to the controller; tran_byte status back to
// the SPI slave; drop_count saturating count of dropped packets.
// Build option: PKT_CHECKSUM_EN (9-byte packets with XOR checksum).
module sphere_packet_receiver
   import Types::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             CLK100MHZ,
   input  logic             ck_rst,
   input  logic             spi_frame_active,
   input  logic             spi_byte_dv,
   input  logic [7:0]       spi_byte,
   input  logic             recv_interrupt,
   output logic             recv_dv,
   output Sphere            recv_64bit,
   output logic [7:0]       tran_byte,
   output logic [CNT_W-1:0] drop_count
);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   asm_state_t            state;
   asm_state_t            state_nxt;
   logic [BYTE_CNT_W-1:0] byte_cnt;
   Sphere                 asm_word;
   logic                  byte_acc_c;
   logic                  load_first_c;
   logic                  load_next_c;
   logic                  commit_c;
   logic                  chk_ok_c;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic [LVL_W-1:0]      fifo_level;
   Sphere                 fifo_head_c;
   logic                  push_c;
   logic                  pop_c;
   logic                  ovf_drop_c;
   logic                  err_drop_c;

   logic                  irq_q;
   logic                  irq_rise_c;
   logic                  pending;
   logic                  ovf_sticky;
   logic                  err_sticky;
   logic [ST_LEVEL_W-1:0] level_sat_c;
   logic [7:0]            status_c;

   assign byte_acc_c = spi_byte_dv && spi_frame_active;

   // Assembler state register
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) state <= ASM_IDLE;
      else        state <= state_nxt;
   end

   // Assembler next state and control strobes
   always_comb begin
      state_nxt    = state;
      load_first_c = 1'b0;
      load_next_c  = 1'b0;
      commit_c     = 1'b0;
      case (state)
         ASM_IDLE: begin
            if (byte_acc_c) begin
               load_first_c = 1'b1;
               state_nxt    = ASM_ASSEMBLE;
            end
         end
         ASM_ASSEMBLE: begin
            // Losing chip-select abandons the partial packet without counting it
            if (!spi_frame_active) begin
               state_nxt = ASM_IDLE;
            end else if (byte_acc_c) begin
               load_next_c = 1'b1;
               if (byte_cnt == BYTE_CNT_W'(PKT_BYTES - 1)) state_nxt = ASM_COMMIT;
            end
         end
         ASM_COMMIT: begin
            commit_c  = 1'b1;
            state_nxt = ASM_IDLE;
         end
         default: state_nxt = ASM_IDLE;
      endcase
   end

   // Byte counter and big-endian shift register (first byte ends up in [63:56])
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) begin
         byte_cnt <= '0;
         asm_word <= '0;
      end else if (load_first_c) begin
         byte_cnt <= BYTE_CNT_W'(1);
         asm_word <= {asm_word[SPHERE_W-9:0], spi_byte};
      end else if (load_next_c) begin
         byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
`ifdef PKT_CHECKSUM_EN
         if (byte_cnt < BYTE_CNT_W'(PKT_PAYLOAD_BYTES)) begin
            asm_word <= {asm_word[SPHERE_W-9:0], spi_byte};
         end
`else
         asm_word <= {asm_word[SPHERE_W-9:0], spi_byte};
`endif
      end
   end

`ifdef PKT_CHECKSUM_EN
   logic [7:0] chk_acc;
   logic [7:0] chk_byte;

   // Running XOR of the payload; the trailing byte is captured separately
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) begin
         chk_acc  <= '0;
         chk_byte <= '0;
      end else if (load_first_c) begin
         chk_acc <= spi_byte;
      end else if (load_next_c) begin
         if (byte_cnt < BYTE_CNT_W'(PKT_PAYLOAD_BYTES)) chk_acc  <= chk_acc ^ spi_byte;
         else                                           chk_byte <= spi_byte;
      end
   end

   assign chk_ok_c = (chk_acc == chk_byte);
`else
   assign chk_ok_c = 1'b1;
`endif

   // Delivery: one pop per rising edge, or a deferred pop once data arrives
   assign irq_rise_c = recv_interrupt && !irq_q;
   assign pop_c      = !fifo_empty && (irq_rise_c || pending);

   // A full FIFO still accepts the packet when the head leaves in the same cycle
   assign err_drop_c = commit_c && !chk_ok_c;
   assign ovf_drop_c = commit_c && chk_ok_c && fifo_full && !pop_c;
   assign push_c     = commit_c && chk_ok_c && (!fifo_full || pop_c);

   word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SPHERE_W)
   ) u_word_fifo (
      .clk    (CLK100MHZ),
      .rst    (ck_rst),
      .push   (push_c),
      .din    (asm_word),
      .pop    (pop_c),
      .head_c (fifo_head_c),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .level  (fifo_level)
   );

   // Controller handshake and output word
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) begin
         irq_q      <= 1'b0;
         pending    <= 1'b0;
         recv_dv    <= 1'b0;
         recv_64bit <= '0;
      end else begin
         irq_q   <= recv_interrupt;
         recv_dv <= pop_c;
         if (pop_c) recv_64bit <= fifo_head_c;
         if (pop_c)                 pending <= 1'b0;
         else if (irq_rise_c)       pending <= 1'b1;
         else if (!recv_interrupt)  pending <= 1'b0;
      end
   end

   // Drop accounting
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) begin
         drop_count <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         if ((ovf_drop_c || err_drop_c) && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
         end
         if (ovf_drop_c) ovf_sticky <= 1'b1;
      end
   end

`ifdef PKT_CHECKSUM_EN
   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst)          err_sticky <= 1'b0;
      else if (err_drop_c) err_sticky <= 1'b1;
   end
`else
   assign err_sticky = 1'b0;
`endif

   // Status byte with occupancy saturated to three bits
   always_comb begin
      if (32'(fifo_level) > ST_LEVEL_MAX) level_sat_c = ST_LEVEL_W'(ST_LEVEL_MAX);
      else                                level_sat_c = ST_LEVEL_W'(fifo_level);
      status_c                   = '0;
      status_c[ST_OVF_BIT]       = ovf_sticky;
      status_c[ST_ERR_BIT]       = err_sticky;
      status_c[ST_LEVEL_W-1:0]   = level_sat_c;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (ck_rst) tran_byte <= '0;
      else        tran_byte <= status_c;
   end

endmodule
